// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The request struct uses the default widths; parameterised modules pack their own flat words.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  localparam logic [1:0] WM_WORD = 2'd0;
  localparam logic [1:0] WM_HALF = 2'd1;
  localparam logic [1:0] WM_BYTE = 2'd2;

  localparam int RF_WIDTH    = 32;
  localparam int RF_ADDR_LEN = 5;

  typedef struct packed {
    logic [RF_ADDR_LEN-1:0] addr;
    logic [RF_WIDTH-1:0]    data;
    logic [1:0]             w_mode;
  } wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO holding queued long-latency register writes.
// Pushes into a full FIFO and pops from an empty one are ignored.
module rf_wr_fifo #(
  parameter int DW    = 39,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between WB and a queued long-latency unit,
// raising a one-cycle pipeline stall when a queued write has been blocked too long.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_wr_en,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  input  logic [WIDTH-1:0]        wb_data,
  input  logic [1:0]              wb_w_mode,
  input  logic                    md_valid,
  output logic                    md_ready,
  input  logic [REG_ADDR_LEN-1:0] md_addr,
  input  logic [WIDTH-1:0]        md_data,
  input  logic [1:0]              md_w_mode,
  output logic                    pipe_stall,
  output logic                    rf_wr_en,
  output logic [REG_ADDR_LEN-1:0] rf_addr,
  output logic [WIDTH-1:0]        rf_data,
  output logic [1:0]              rf_w_mode,
  output logic                    md_pending
);

  localparam int DW = REG_ADDR_LEN + WIDTH + 2;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  arb_state_e              state;
  arb_state_e              next_state;
  logic [SW-1:0]           starve_cnt;
  logic [SW-1:0]           starve_cnt_next;
  logic [DW-1:0]           head_word;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           count_next;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    grant;
  logic                    stall_trigger;
  logic [REG_ADDR_LEN-1:0] head_addr;
  logic [WIDTH-1:0]        head_data;
  logic [1:0]              head_w_mode;
  logic [REG_ADDR_LEN-1:0] sel_addr;
  logic [WIDTH-1:0]        sel_data;
  logic [1:0]              sel_w_mode;

  rf_wr_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({md_addr, md_data, md_w_mode}),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_addr, head_data, head_w_mode} = head_word;
  assign md_ready   = !fifo_full;
  assign md_pending = !fifo_empty;
  assign pipe_stall = (state == STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Grant priority: forced FIFO drain during a stall, then WB, then opportunistic drain.
  always_comb begin
    push            = md_valid && !fifo_full;
    pop             = 1'b0;
    grant           = 1'b0;
    sel_addr        = wb_addr;
    sel_data        = wb_data;
    sel_w_mode      = wb_w_mode;
    stall_trigger   = 1'b0;
    starve_cnt_next = '0;
    next_state      = IDLE;

    if (pipe_stall && !fifo_empty) begin
      pop   = 1'b1;
      grant = 1'b1;
    end else if (wb_wr_en) begin
      grant = 1'b1;
    end else if (!fifo_empty) begin
      pop   = 1'b1;
      grant = 1'b1;
    end

    if (pop) begin
      sel_addr   = head_addr;
      sel_data   = head_data;
      sel_w_mode = head_w_mode;
    end

    if (!fifo_empty && !pop) begin
      if (starve_cnt == SW'(STARVE_LIMIT - 1)) stall_trigger = 1'b1;
      else                                     starve_cnt_next = starve_cnt + SW'(1);
    end

    count_next = fifo_count + CW'(push) - CW'(pop);
    if (stall_trigger)          next_state = STALL;
    else if (count_next != '0)  next_state = DRAIN;
  end

  // Field registers only load on a grant so an idle cycle leaves the port quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en  <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      rf_w_mode <= '0;
    end else begin
      rf_wr_en <= grant;
      if (grant) begin
        rf_addr   <= sel_addr;
        rf_data   <= sel_data;
        rf_w_mode <= sel_w_mode;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a behavioural queue model predicts every write-port
// pulse plus stall/ready/pending, and the negedge checker compares the DUT against it.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int W     = 32;
  localparam int AL    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_wr_en;
  logic [AL-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [1:0]    wb_w_mode;
  logic          md_valid;
  logic          md_ready;
  logic [AL-1:0] md_addr;
  logic [W-1:0]  md_data;
  logic [1:0]    md_w_mode;
  logic          pipe_stall;
  logic          rf_wr_en;
  logic [AL-1:0] rf_addr;
  logic [W-1:0]  rf_data;
  logic [1:0]    rf_w_mode;
  logic          md_pending;

  int checks = 0;
  int errors = 0;

  wr_req_t m_fifo[$];
  wr_req_t exp_q[$];
  int      m_cnt;
  logic    m_stall;

  rf_write_arbiter #(
    .WIDTH        (W),
    .REG_ADDR_LEN (AL),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_wr_en   (wb_wr_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_w_mode  (wb_w_mode),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_addr    (md_addr),
    .md_data    (md_data),
    .md_w_mode  (md_w_mode),
    .pipe_stall (pipe_stall),
    .rf_wr_en   (rf_wr_en),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rf_w_mode  (rf_w_mode),
    .md_pending (md_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; WB is suppressed while the DUT stalls, as upstream must do.
  task automatic applyStimulus(input logic wb_en, input logic [AL-1:0] wa, input logic [W-1:0] wd,
                               input logic [1:0] wm, input logic mv, input logic [AL-1:0] ma,
                               input logic [W-1:0] mdd, input logic [1:0] mm);
    @(negedge clk);
    wb_wr_en  = wb_en && !pipe_stall;
    wb_addr   = wa;
    wb_data   = wd;
    wb_w_mode = wm;
    md_valid  = mv;
    md_addr   = ma;
    md_data   = mdd;
    md_w_mode = mm;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, WM_WORD, 0, '0, '0, WM_WORD);
  endtask

  // Reference model: queue-based arbitration, evaluated on each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete();
      exp_q.delete();
      m_cnt   = 0;
      m_stall = 1'b0;
    end else begin
      wr_req_t req;
      wr_req_t head;
      bit      was_empty;
      bit      popped;
      bit      do_push;
      bit      next_stall;
      was_empty  = (m_fifo.size() == 0);
      do_push    = md_valid && (m_fifo.size() < DEPTH);
      popped     = 0;
      next_stall = 0;
      req.addr   = md_addr;
      req.data   = md_data;
      req.w_mode = md_w_mode;
      if (!was_empty && (m_stall || !wb_wr_en)) begin
        head   = m_fifo.pop_front();
        popped = 1;
        exp_q.push_back(head);
      end else if (wb_wr_en) begin
        head.addr   = wb_addr;
        head.data   = wb_data;
        head.w_mode = wb_w_mode;
        exp_q.push_back(head);
      end
      if (do_push) m_fifo.push_back(req);
      if (was_empty || popped) m_cnt = 0;
      else if (m_cnt == LIMIT - 1) begin
        m_cnt      = 0;
        next_stall = 1;
      end else m_cnt = m_cnt + 1;
      m_stall = next_stall;
    end
  end

  always @(posedge clk) begin
    assert (!(rst_n && pipe_stall && wb_wr_en))
      else $error("[TB] protocol violation: wb_wr_en during pipe_stall");
  end

  // Scoreboard checker: every negedge, compare flags and pop one expected write per pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("pipe_stall", pipe_stall, m_stall);
      checkOutput("md_ready", md_ready, m_fifo.size() != DEPTH);
      checkOutput("md_pending", md_pending, m_fifo.size() != 0);
      checkOutput("rf_wr_en", rf_wr_en, exp_q.size() != 0);
      if (rf_wr_en && exp_q.size() != 0) begin
        wr_req_t e;
        e = exp_q.pop_front();
        checkOutput("rf_addr", rf_addr, e.addr);
        checkOutput("rf_data", rf_data, e.data);
        checkOutput("rf_w_mode", rf_w_mode, e.w_mode);
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, rf_wr_en, 0);
    checkOutput({tag, "_addr"}, rf_addr, 0);
    checkOutput({tag, "_data"}, rf_data, 0);
    checkOutput({tag, "_w_mode"}, rf_w_mode, 0);
    checkOutput({tag, "_stall"}, pipe_stall, 0);
    checkOutput({tag, "_ready"}, md_ready, 1);
    checkOutput({tag, "_pending"}, md_pending, 0);
  endtask

  initial begin
    int accepted;
    int stall_seen;
    bit saw_full;
    rst_n     = 1'b0;
    wb_wr_en  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    wb_w_mode = '0;
    md_valid  = 1'b0;
    md_addr   = '0;
    md_data   = '0;
    md_w_mode = '0;
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single long-latency write with an otherwise idle port.
    applyStimulus(0, '0, '0, WM_WORD, 1, 5'd7, 32'h1234_5678, WM_WORD);
    idleCycles(4);
    checkOutput("md_pending_end", md_pending, 0);

    // WB and FIFO head contend: WB first, queued write next.
    applyStimulus(0, '0, '0, WM_WORD, 1, 5'd4, 32'h4444_0004, WM_HALF);
    applyStimulus(1, 5'd3, 32'hAAAA_0000, WM_WORD, 0, '0, '0, WM_WORD);
    idleCycles(3);

    // Saturating WB starves one queued entry until the stall fires.
    stall_seen = 0;
    applyStimulus(0, '0, '0, WM_WORD, 1, 5'd9, 32'h9999_0009, WM_BYTE);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1, AL'(c + 1), 32'hD000_0000 + c, WM_WORD, 0, '0, '0, WM_WORD);
      if (pipe_stall) stall_seen++;
    end
    checkOutput("stall_cycles", stall_seen, 1);
    idleCycles(3);

    // Three back-to-back offers into a depth-2 FIFO under WB saturation.
    accepted = 0;
    saw_full = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1, AL'(c % 8), 32'hB000_0000 + c, WM_WORD,
                    accepted < 3, AL'(20 + accepted), 32'hC0 + accepted, WM_HALF);
      if (md_valid && md_ready) accepted++;
      if (!md_ready) saw_full = 1;
    end
    checkOutput("md_accepts", accepted, 3);
    checkOutput("saw_full", saw_full, 1);
    idleCycles(6);

    // Push while the single queued entry pops.
    applyStimulus(0, '0, '0, WM_WORD, 1, 5'd11, 32'h0000_0011, WM_WORD);
    applyStimulus(0, '0, '0, WM_WORD, 1, 5'd12, 32'h0000_0012, WM_BYTE);
    applyStimulus(0, '0, '0, WM_WORD, 0, '0, '0, WM_WORD);
    checkOutput("overlap_pending", md_pending, 1);
    checkOutput("overlap_ready", md_ready, 1);
    idleCycles(3);

    // Reset with two queued entries; nothing may be written afterwards.
    applyStimulus(1, 5'd1, 32'h0000_0101, WM_WORD, 1, 5'd13, 32'h0000_0013, WM_WORD);
    applyStimulus(1, 5'd2, 32'h0000_0202, WM_WORD, 1, 5'd14, 32'h0000_0014, WM_WORD);
    applyStimulus(1, 5'd5, 32'h0000_0505, WM_WORD, 0, '0, '0, WM_WORD);
    checkOutput("pre_reset_pending", md_pending, 1);
    #2 rst_n = 1'b0;
    wb_wr_en = 1'b0;
    md_valid = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(6);

    // Randomised traffic against the model.
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), AL'($urandom), $urandom, 2'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), AL'($urandom), $urandom, 2'($urandom_range(0, 2)));
    end
    idleCycles(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
